// File: rtl/ram_chip.sv
// 4002-style data RAM chip for the 4-bit multiplexed CPU bus: follows the 8-clock
// instruction cycle, latches SRC addresses and executes the RAM/I-O opcode group.
module ram_chip #(
    parameter logic [1:0] CHIP_ID  = 2'd0,
    parameter int         NUM_REGS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    inout  wire  [3:0] data,
    input  logic       sync,
    input  logic       cmd_n,
    output logic [3:0] out
);
    localparam logic [2:0] CYC_M2    = 3'd4;
    localparam logic [2:0] CYC_X2    = 3'd6;
    localparam logic [2:0] CYC_X3    = 3'd7;
    localparam logic [1:0] LAST_REG  = 2'(NUM_REGS - 1);
    localparam logic [2:0] REG_LIMIT = 3'(NUM_REGS);

    logic [2:0] cycle_r;
    logic       selected_r;
    logic       src_pending_r;
    logic [1:0] reg_addr_r;
    logic [3:0] char_addr_r;
    logic [3:0] inst_r;
    logic       inst_active_r;
    logic [3:0] out_r;
    logic [3:0] main_r [64];
    logic [3:0] stat_r [16];

    logic       src_cmd_s;
    logic       op_cmd_s;
    logic       src_hit_s;
    logic       exec_s;
    logic       wr_main_s;
    logic       wr_out_s;
    logic       wr_stat_s;
    logic       rd_main_s;
    logic       rd_stat_s;
    logic       drive_s;
    logic [5:0] main_idx_s;
    logic [3:0] stat_idx_s;
    logic [3:0] rd_data_s;

    // Instruction-cycle position; sync forces realignment to cycle 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_r <= 3'd0;
        end else if (sync) begin
            cycle_r <= 3'd0;
        end else begin
            cycle_r <= cycle_r + 3'd1;
        end
    end

    // Bus command qualifiers and SRC chip/register match.
    always_comb begin
        src_cmd_s = 1'b0;
        op_cmd_s  = 1'b0;
        src_hit_s = 1'b0;
        if (!cmd_n && (cycle_r == CYC_X2)) begin
            src_cmd_s = 1'b1;
        end else begin
            src_cmd_s = 1'b0;
        end
        if (!cmd_n && (cycle_r == CYC_M2) && selected_r) begin
            op_cmd_s = 1'b1;
        end else begin
            op_cmd_s = 1'b0;
        end
        if ((data[3:2] == CHIP_ID) && ({1'b0, data[1:0]} < REG_LIMIT)) begin
            src_hit_s = 1'b1;
        end else begin
            src_hit_s = 1'b0;
        end
    end

    // SRC address capture: register nibble at X2, character nibble at the following X3.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            selected_r    <= 1'b0;
            src_pending_r <= 1'b0;
            reg_addr_r    <= LAST_REG;
            char_addr_r   <= 4'hF;
        end else if (src_cmd_s) begin
            selected_r <= src_hit_s;
            if (src_hit_s) begin
                reg_addr_r    <= data[1:0];
                src_pending_r <= 1'b1;
            end
        end else if ((cycle_r == CYC_X3) && src_pending_r) begin
            char_addr_r   <= data;
            src_pending_r <= 1'b0;
        end
    end

    // Opcode capture at M2; the op is retired at X3 or abandoned on an early sync.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inst_r        <= 4'h0;
            inst_active_r <= 1'b0;
        end else if (sync || (cycle_r == CYC_X3)) begin
            inst_active_r <= 1'b0;
        end else if (op_cmd_s) begin
            inst_r        <= data;
            inst_active_r <= 1'b1;
        end
    end

    // Opcode decode for the execution slot.
    always_comb begin
        wr_main_s  = 1'b0;
        wr_out_s   = 1'b0;
        wr_stat_s  = 1'b0;
        rd_main_s  = 1'b0;
        rd_stat_s  = 1'b0;
        exec_s     = inst_active_r && selected_r && (cycle_r == CYC_X2);
        main_idx_s = {reg_addr_r, char_addr_r};
        stat_idx_s = {reg_addr_r, inst_r[1:0]};
        case (inst_r)
            4'h0:                      wr_main_s = exec_s;
            4'h1:                      wr_out_s  = exec_s;
            4'h4, 4'h5, 4'h6, 4'h7:    wr_stat_s = exec_s;
            4'h8, 4'h9, 4'hB:          rd_main_s = exec_s;
            4'hC, 4'hD, 4'hE, 4'hF:    rd_stat_s = exec_s;
            default: begin
                wr_main_s = 1'b0;
                rd_main_s = 1'b0;
            end
        endcase
        if (rd_main_s) begin
            rd_data_s = main_r[main_idx_s];
        end else begin
            rd_data_s = stat_r[stat_idx_s];
        end
        drive_s = rd_main_s || rd_stat_s;
    end

    // Bus driver is combinational so it drops the instant X2 ends or reset asserts.
    assign data = drive_s ? rd_data_s : 4'bzzzz;

    // Output port register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= 4'h0;
        end else if (wr_out_s) begin
            out_r <= data;
        end
    end

    assign out = out_r;

    // Main and status character storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                main_r[i] <= 4'h0;
            end
            for (int j = 0; j < 16; j++) begin
                stat_r[j] <= 4'h0;
            end
        end else begin
            if (wr_main_s) begin
                main_r[main_idx_s] <= data;
            end
            if (wr_stat_s) begin
                stat_r[stat_idx_s] <= data;
            end
        end
    end
endmodule

// File: tb/tb_ram_chip.sv
// Two RAM chips (ID 2 with 4 registers, ID 1 with 2 registers) on one shared bus,
// driven by instruction-level transactions and checked against an array model.
module tb_ram_chip;
    localparam logic [1:0] ID_A   = 2'd2;
    localparam int         NREG_A = 4;
    localparam logic [1:0] ID_B   = 2'd1;
    localparam int         NREG_B = 2;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       sync    = 1'b0;
    logic       cmd_n   = 1'b1;
    logic       bus_en  = 1'b1;
    logic [3:0] bus_val = 4'h0;
    wire  [3:0] data;
    logic [3:0] out_a;
    logic [3:0] out_b;

    assign data = bus_en ? bus_val : 4'bzzzz;

    ram_chip #(.CHIP_ID(ID_A), .NUM_REGS(NREG_A)) u_a (
        .clock(clock), .reset_n(reset_n), .data(data), .sync(sync), .cmd_n(cmd_n), .out(out_a)
    );
    ram_chip #(.CHIP_ID(ID_B), .NUM_REGS(NREG_B)) u_b (
        .clock(clock), .reset_n(reset_n), .data(data), .sync(sync), .cmd_n(cmd_n), .out(out_b)
    );

    always #5 clock = ~clock;

    // Behavioural model: per-chip selection, address and memories.
    logic [1:0] m_id   [2];
    int         m_n    [2];
    bit         m_sel  [2];
    logic [1:0] m_reg  [2];
    logic [3:0] m_char [2];
    logic [3:0] m_out  [2] = '{4'h0, 4'h0};
    logic [3:0] m_main [2][64];
    logic [3:0] m_stat [2][16];

    bit         exp_drive = 1'b0;
    logic [3:0] exp_rd    = 4'h0;
    bit         in_c6     = 1'b0;
    logic [3:0] seen6     = 4'h0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle compare of bus and output ports against the model.
    always @(negedge clock) begin
        logic [3:0] want;
        want = exp_drive ? exp_rd : bus_val;
        check("data", data, want);
        check("out_a", out_a, m_out[0]);
        check("out_b", out_b, m_out[1]);
        if (in_c6) seen6 = data;
    end

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sel[c]  = 1'b0;
            m_reg[c]  = 2'(m_n[c] - 1);
            m_char[c] = 4'hF;
            m_out[c]  = 4'h0;
            for (int i = 0; i < 64; i++) m_main[c][i] = 4'h0;
            for (int i = 0; i < 16; i++) m_stat[c][i] = 4'h0;
        end
    endtask

    task automatic tick(input logic cmd, input logic drv, input logic [3:0] val, input logic syn);
        cmd_n   = cmd;
        bus_en  = drv;
        bus_val = val;
        sync    = syn;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        exp_drive = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) tick(1'($urandom), 1'b1, 4'($urandom), 1'($urandom));
        reset_n = 1'b1;
    endtask

    // One full 8-clock instruction cycle: optional opcode at M2, optional SRC at X2.
    task automatic instr(input bit op_en, input logic [3:0] opc, input bit src_en,
                         input logic [3:0] v6, input logic [3:0] v7);
        int s;
        bit pend [2];
        s = -1;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0;
            if (m_sel[c]) s = c;
        end
        for (int cy = 0; cy < 4; cy++) tick(1'b1, 1'b1, 4'($urandom), 1'b0);
        tick(!op_en, 1'b1, op_en ? opc : 4'($urandom), 1'b0);
        tick(1'b1, 1'b1, 4'($urandom), 1'b0);
        exp_drive = 1'b0;
        if (op_en && s >= 0) begin
            if (opc == 4'h8 || opc == 4'h9 || opc == 4'hB) begin
                exp_drive = 1'b1;
                exp_rd = m_main[s][m_reg[s] * 16 + m_char[s]];
            end else if (opc >= 4'hC) begin
                exp_drive = 1'b1;
                exp_rd = m_stat[s][m_reg[s] * 4 + opc[1:0]];
            end
        end
        in_c6 = 1'b1;
        tick(!src_en, !exp_drive, v6, 1'b0);
        in_c6 = 1'b0;
        exp_drive = 1'b0;
        if (op_en && s >= 0) begin
            if (opc == 4'h0) m_main[s][m_reg[s] * 16 + m_char[s]] = v6;
            else if (opc == 4'h1) m_out[s] = v6;
            else if (opc >= 4'h4 && opc <= 4'h7) m_stat[s][m_reg[s] * 4 + opc[1:0]] = v6;
        end
        if (src_en) begin
            for (int c = 0; c < 2; c++) begin
                m_sel[c] = (v6[3:2] == m_id[c]) && (int'(v6[1:0]) < m_n[c]);
                if (m_sel[c]) begin
                    m_reg[c] = v6[1:0];
                    pend[c]  = 1'b1;
                end
            end
        end
        tick(1'b1, 1'b1, v7, 1'b1);
        for (int c = 0; c < 2; c++) if (pend[c]) m_char[c] = v7;
    endtask

    task automatic src(input logic [3:0] cr, input logic [3:0] ch);
        instr(1'b0, 4'h0, 1'b1, cr, ch);
    endtask

    task automatic op(input logic [3:0] opc, input logic [3:0] v);
        instr(1'b1, opc, 1'b0, v, 4'($urandom));
    endtask

    // Partial instruction cycle of len clocks ending with an early sync.
    task automatic resync(input int len);
        for (int cy = 0; cy < len; cy++) tick(1'b1, 1'b1, 4'($urandom), cy == len - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        m_id[0] = ID_A;
        m_id[1] = ID_B;
        m_n[0]  = NREG_A;
        m_n[1]  = NREG_B;
        model_reset();

        // reset with garbage on the bus, then reads return zero
        do_reset(5);
        check("lit_out_reset", out_a, 4'h0);
        op(4'h9, 4'h3);
        src(4'h8, 4'h0);
        op(4'h9, 4'h0);
        check("lit_rdm_reset", seen6, 4'h0);

        // main memory round trip on reg 3 char 5 of chip 2
        src(4'hB, 4'h5);
        op(4'h0, 4'h9);
        op(4'h9, 4'h0);
        check("lit_rdm_9", seen6, 4'h9);
        src(4'hB, 4'h4);
        op(4'h9, 4'h0);
        check("lit_rdm_c4", seen6, 4'h0);
        src(4'hB, 4'h6);
        op(4'hB, 4'h0);
        check("lit_adm_c6", seen6, 4'h0);

        // chip-select miss leaves the character untouched
        src(4'h3, 4'h5);
        op(4'h0, 4'h7);
        op(4'h9, 4'h2);
        src(4'hB, 4'h5);
        op(4'h8, 4'h0);
        check("lit_miss_keep", seen6, 4'h9);

        // status characters on reg 1
        src(4'h9, 4'h0);
        op(4'h6, 4'hA);
        op(4'h4, 4'h1);
        op(4'hE, 4'h0);
        check("lit_rd2", seen6, 4'hA);
        op(4'hC, 4'h0);
        check("lit_rd0", seen6, 4'h1);
        op(4'hD, 4'h0);
        check("lit_rd1", seen6, 4'h0);
        src(4'h8, 4'h0);
        op(4'hE, 4'h0);
        check("lit_rd2_reg0", seen6, 4'h0);

        // output port holds across other ops
        op(4'h1, 4'h6);
        check("lit_out_6", out_a, 4'h6);
        op(4'h9, 4'h0);
        op(4'h0, 4'h3);
        op(4'h2, 4'hF);
        check("lit_out_held", out_a, 4'h6);

        // chip 1 (2 registers): out-of-range register deselects, then resync
        src(4'h7, 4'h2);
        op(4'h0, 4'h5);
        src(4'h5, 4'hF);
        op(4'h9, 4'h0);
        check("lit_b_nowrite", seen6, 4'h0);
        resync(4);
        src(4'h4, 4'h3);
        op(4'h0, 4'hD);
        op(4'h9, 4'h0);
        check("lit_b_resync", seen6, 4'hD);

        // op and SRC in the same instruction cycle
        src(4'hA, 4'h1);
        instr(1'b1, 4'h0, 1'b1, 4'h9, 4'h2);
        op(4'h9, 4'h0);
        src(4'hA, 4'h1);
        op(4'h9, 4'h0);
        check("lit_same_cycle", seen6, 4'h9);

        // reset in the middle of a write deselects the chip
        src(4'hA, 4'h1);
        for (int cy = 0; cy < 4; cy++) tick(1'b1, 1'b1, 4'($urandom), 1'b0);
        tick(1'b0, 1'b1, 4'h0, 1'b0);
        #2;
        do_reset(3);
        op(4'h9, 4'h6);
        src(4'hA, 4'h1);
        op(4'h9, 4'h0);
        check("lit_reset_mid", seen6, 4'h0);

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [3:0] opc;
            kind = int'($urandom_range(0, 9));
            opc  = 4'($urandom);
            if (kind < 3) begin
                src(4'($urandom), 4'($urandom));
            end else if (kind == 3) begin
                resync(int'($urandom_range(1, 6)));
            end else if (kind == 4 && opc < 4'h8) begin
                instr(1'b1, opc, 1'b1, 4'($urandom), 4'($urandom));
            end else begin
                op(opc, 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
